// File: rtl/kyber_pkg.sv
// kyber_pkg: constants and types shared by the Kyber serialisation datapath.
//   KYBER_Q / KYBER_N / KYBER_Q_HALF : modulus, polynomial length, rounding offset
//   coeff_t                          : signed 16-bit coefficient
//   state_e                          : collector FSM states
//   d_legal()                        : compression-width legality check
package kyber_pkg;

    localparam int KYBER_Q      = 3329;
    localparam int KYBER_N      = 256;
    localparam int KYBER_Q_HALF = 1664;

    typedef logic signed [15:0] coeff_t;

    typedef enum logic {
        StFill,
        StFull
    } state_e;

    function automatic bit d_legal(input int d);
        return (d >= 1) && (d <= 11);
    endfunction

endpackage

// File: rtl/poly_compress_collect_if.sv
// poly_compress_collect_if: coefficient input stream and compressed-polynomial output.
//   in_valid / in_ready / in_coeff : one coefficient per transfer
//   out_valid / out_ack            : F_out holds a complete polynomial / consumer took it
//   F_out                          : 256 compressed coefficients, zero-extended
// Modports: master = producer/consumer side, slave = the collector.
interface poly_compress_collect_if;
    import kyber_pkg::*;

    logic   in_valid;
    logic   in_ready;
    coeff_t in_coeff;
    logic   out_valid;
    logic   out_ack;
    coeff_t F_out [KYBER_N];

    modport master (
        output in_valid, in_coeff, out_ack,
        input  in_ready, out_valid, F_out
    );

    modport slave (
        input  in_valid, in_coeff, out_ack,
        output in_ready, out_valid, F_out
    );

endinterface

// File: rtl/compress_unit.sv
// compress_unit: Kyber Compress_D on one coefficient, split at a register boundary.
//   coeff   : raw coefficient in [-Q, 2Q-1]
//   canon   : coeff reduced to [0, Q-1] (registered outside, fed back as canon_q)
//   canon_q : registered canonical value
//   comp    : floor(((canon_q << D) + Q/2) / Q) mod 2^D
module compress_unit
    import kyber_pkg::*;
#(
    parameter int unsigned D = 10
) (
    input  coeff_t         coeff,
    output logic [11:0]    canon,
    input  logic [11:0]    canon_q,
    output logic [D-1:0]   comp
);

    localparam logic signed [16:0] QS = signed'(17'(KYBER_Q));

    logic signed [16:0] x;
    logic signed [16:0] t;
    logic        [22:0] num;
    logic        [22:0] quot;
    logic               unused_bits;

    always_comb begin
        x = {coeff[15], coeff};
        if (x[16]) begin
            t = x + QS;
        end else if (x >= QS) begin
            t = x - QS;
        end else begin
            t = x;
        end
        canon = t[11:0];
    end

    // 3328 << 11 plus the offset still fits in 23 bits; the constant divide is exact.
    always_comb begin
        num  = (23'(canon_q) << D) + 23'(KYBER_Q_HALF);
        quot = num / 23'(KYBER_Q);
        comp = quot[D-1:0];
    end

    assign unused_bits = ^{t[16:12], quot[22:D]};

endmodule

// File: rtl/poly_compress_collect.sv
// poly_compress_collect: compresses a stream of 256 coefficients into a registered
// polynomial for the byte encoder.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of poly_compress_collect_if (input stream, F_out, out_valid/ack)
// Pipeline: accept -> s0 (raw) -> s1 (canonical) -> F_out[wr_cnt]; two edges accept-to-write.
module poly_compress_collect
    import kyber_pkg::*;
#(
    parameter int unsigned D = 10,
    parameter int unsigned Q = 3329,
    parameter int unsigned N = 256
) (
    input logic                    clk,
    input logic                    rst_n,
    poly_compress_collect_if.slave bus
);

    if (!d_legal(int'(D)) || Q != KYBER_Q || N != KYBER_N) begin : g_bad_param
        $error("poly_compress_collect: D must be 1..11, Q and N are fixed");
    end

    state_e      state_q, state_d;
    logic [8:0]  acc_q, acc_d;
    logic [7:0]  wr_q, wr_d;
    logic        v0_q, v1_q;
    coeff_t      s0_q;
    logic [11:0] s1_q;
    logic [11:0] canon;
    logic [D-1:0] comp;
    coeff_t      f_entry;
    coeff_t      f_q [KYBER_N];
    logic        in_ready;
    logic        accept;

    compress_unit #(
        .D(D)
    ) u_compress (
        .coeff   (s0_q),
        .canon   (canon),
        .canon_q (s1_q),
        .comp    (comp)
    );

    assign in_ready      = (state_q == StFill) && !acc_q[8];
    assign accept        = bus.in_valid && in_ready;
    assign f_entry       = coeff_t'({{(16 - D){1'b0}}, comp});
    assign bus.in_ready  = in_ready;
    assign bus.out_valid = (state_q == StFull);
    assign bus.F_out     = f_q;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        wr_d    = wr_q;
        if (accept) begin
            acc_d = acc_q + 9'd1;
        end
        if (v1_q) begin
            wr_d = wr_q + 8'd1;
            if (wr_q == 8'd255) begin
                state_d = StFull;
            end
        end
        // Pipeline is empty in FULL, so release never races a write.
        if (state_q == StFull && bus.out_ack) begin
            state_d = StFill;
            acc_d   = '0;
            wr_d    = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StFill;
            acc_q   <= '0;
            wr_q    <= '0;
            v0_q    <= 1'b0;
            v1_q    <= 1'b0;
            s0_q    <= '0;
            s1_q    <= '0;
            for (int i = 0; i < KYBER_N; i++) begin
                f_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            wr_q    <= wr_d;
            v0_q    <= accept;
            v1_q    <= v0_q;
            if (accept) begin
                s0_q <= bus.in_coeff;
            end
            if (v0_q) begin
                s1_q <= canon;
            end
            if (v1_q) begin
                f_q[wr_q] <= f_entry;
            end
        end
    end

endmodule

// File: tb/tb_poly_compress_collect.sv
// tb_poly_compress_collect: four collectors (D = 4, 1, 10, 11) fed the same stream.
module tb_poly_compress_collect;
    import kyber_pkg::*;

    logic   clk;
    logic   rst_n;
    logic   in_valid;
    coeff_t in_coeff;
    logic   out_ack;

    int checks;
    int errors;
    int coeffs [256];

    poly_compress_collect_if b4 ();
    poly_compress_collect_if b1 ();
    poly_compress_collect_if b10 ();
    poly_compress_collect_if b11 ();

    assign b4.in_valid  = in_valid;
    assign b4.in_coeff  = in_coeff;
    assign b4.out_ack   = out_ack;
    assign b1.in_valid  = in_valid;
    assign b1.in_coeff  = in_coeff;
    assign b1.out_ack   = out_ack;
    assign b10.in_valid = in_valid;
    assign b10.in_coeff = in_coeff;
    assign b10.out_ack  = out_ack;
    assign b11.in_valid = in_valid;
    assign b11.in_coeff = in_coeff;
    assign b11.out_ack  = out_ack;

    poly_compress_collect #(.D(4))  dut4  (.clk(clk), .rst_n(rst_n), .bus(b4));
    poly_compress_collect #(.D(1))  dut1  (.clk(clk), .rst_n(rst_n), .bus(b1));
    poly_compress_collect #(.D(10)) dut10 (.clk(clk), .rst_n(rst_n), .bus(b10));
    poly_compress_collect #(.D(11)) dut11 (.clk(clk), .rst_n(rst_n), .bus(b11));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int ref_compress(input int x, input int d);
        int r;
        r = x;
        if (r < 0) r = r + 3329;
        else if (r >= 3329) r = r - 3329;
        return (((r << d) + 1664) / 3329) % (1 << d);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_coeffs();
        for (int i = 0; i < 256; i++) begin
            coeffs[i] = int'($urandom_range(9986)) - 3329;
        end
    endtask

    // Offers coeffs[0..count-1]; duty is the in_valid percentage.
    task automatic feed(input int duty, input bit rand_ack, input int count);
        int   idx;
        int   cyc;
        logic took;
        idx = 0;
        cyc = 0;
        while (idx < count && cyc < 4000) begin
            in_valid = ($urandom_range(99) < duty);
            in_coeff = coeff_t'(coeffs[idx]);
            out_ack  = rand_ack ? 1'($urandom_range(1)) : 1'b0;
            took     = in_valid && b4.in_ready;
            tick();
            if (took) idx++;
            cyc++;
        end
        in_valid = 1'b0;
        out_ack  = 1'b0;
        check("feed_accepts", idx, count);
    endtask

    // Called #1 after the edge of the 256th accept.
    task automatic drain();
        check("drain1_valid", b4.out_valid, 0);
        check("drain1_ready", b4.in_ready, 0);
        tick();
        check("drain2_valid", b4.out_valid, 0);
        check("drain2_ready", b4.in_ready, 0);
        tick();
        check("full_valid", b4.out_valid, 1);
        check("full_ready", b4.in_ready, 0);
        check("full_valid_d1", b1.out_valid, 1);
    endtask

    task automatic release_poly();
        out_ack = 1'b1;
        tick();
        out_ack = 1'b0;
        check("release_valid", b4.out_valid, 0);
        check("release_ready", b4.in_ready, 1);
    endtask

    task automatic check_poly(input string tag);
        for (int i = 0; i < 256; i++) begin
            check($sformatf("%s_d4[%0d]", tag, i), b4.F_out[i], ref_compress(coeffs[i], 4));
            check($sformatf("%s_d1[%0d]", tag, i), b1.F_out[i], ref_compress(coeffs[i], 1));
            check($sformatf("%s_d10[%0d]", tag, i), b10.F_out[i], ref_compress(coeffs[i], 10));
            check($sformatf("%s_d11[%0d]", tag, i), b11.F_out[i], ref_compress(coeffs[i], 11));
        end
    endtask

    task automatic reset_pulse(input string tag);
        int nz;
        #2;
        rst_n = 1'b0;
        #1;
        nz = 0;
        for (int i = 0; i < 256; i++) begin
            if (b4.F_out[i] !== '0 || b1.F_out[i] !== '0 || b10.F_out[i] !== '0 ||
                b11.F_out[i] !== '0) nz++;
        end
        check({tag, "_valid"}, b4.out_valid, 0);
        check({tag, "_fout_nonzero"}, nz, 0);
        rst_n = 1'b1;
        tick();
        check({tag, "_ready"}, b4.in_ready, 1);
    endtask

    initial begin
        int     acc;
        int     full_cycles;
        int     diffs;
        int     leak;
        bit     have_snap;
        logic   ready_after;
        logic   took;
        coeff_t snap [256];

        checks   = 0;
        errors   = 0;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_coeff = '0;
        out_ack  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", b4.out_valid, 0);
        check("rst_fout0", b4.F_out[0], 0);
        check("rst_fout255", b11.F_out[255], 0);
        #3;
        rst_n = 1'b1;
        tick();
        check("post_rst_ready", b4.in_ready, 1);

        // Directed polynomial: hand-computed values at the interesting indices.
        for (int i = 0; i < 256; i++) coeffs[i] = 0;
        coeffs[0]  = 0;     coeffs[1]  = 1664;  coeffs[2]  = 3328;  coeffs[3]  = -1;
        coeffs[4]  = 208;   coeffs[5]  = 832;   coeffs[6]  = 833;   coeffs[7]  = 2496;
        coeffs[8]  = 2497;  coeffs[9]  = -2497; coeffs[10] = -2496; coeffs[11] = 3329;
        coeffs[12] = 1665;  coeffs[13] = 1;
        feed(100, 1'b0, 256);
        drain();
        check("d4_0", b4.F_out[0], 0);
        check("d4_1", b4.F_out[1], 8);
        check("d4_2", b4.F_out[2], 0);
        check("d4_3", b4.F_out[3], 0);
        check("d4_4", b4.F_out[4], 1);
        check("d1_5", b1.F_out[5], 0);
        check("d1_6", b1.F_out[6], 1);
        check("d1_7", b1.F_out[7], 1);
        check("d1_8", b1.F_out[8], 0);
        check("d1_9", b1.F_out[9], 0);
        check("d1_10", b1.F_out[10], 1);
        check("d1_11", b1.F_out[11], 0);
        check("d10_12", b10.F_out[12], 512);
        check("d10_2", b10.F_out[2], 0);
        check("d11_2", b11.F_out[2], 2047);
        check("d11_13", b11.F_out[13], 1);
        check("d11_12", b11.F_out[12], 1024);
        check_poly("dir");
        release_poly();

        // Back-pressure: in_valid held for 300 cycles, no ack.
        rand_coeffs();
        acc = 0; full_cycles = 0; diffs = 0; leak = 0;
        have_snap = 1'b0; ready_after = 1'b1;
        in_valid = 1'b1;
        for (int c = 0; c < 300; c++) begin
            in_coeff = coeff_t'(coeffs[acc < 256 ? acc : 255]);
            took = in_valid && b4.in_ready;
            tick();
            if (took) begin
                acc++;
                if (acc == 256) ready_after = b4.in_ready;
            end else if (acc >= 256 && b4.in_ready) begin
                leak++;
            end
            if (b4.out_valid) begin
                if (!have_snap) begin
                    snap = b4.F_out;
                    have_snap = 1'b1;
                end else begin
                    full_cycles++;
                    for (int i = 0; i < 256; i++) if (b4.F_out[i] !== snap[i]) diffs++;
                end
            end
        end
        in_valid = 1'b0;
        check("bp_accepts", acc, 256);
        check("bp_ready_after_256", ready_after, 0);
        check("bp_ready_leak", leak, 0);
        check("bp_full_cycles_ge20", full_cycles >= 20, 1);
        check("bp_fout_changes", diffs, 0);
        check_poly("bp");
        release_poly();

        // out_ack with nothing to release.
        out_ack = 1'b1;
        repeat (3) tick();
        out_ack = 1'b0;
        check("stray_ack_valid", b4.out_valid, 0);
        check("stray_ack_ready", b4.in_ready, 1);

        // Three polynomials with random gaps and stray acks during fill.
        for (int p = 0; p < 3; p++) begin
            rand_coeffs();
            feed(50, 1'b1, 256);
            drain();
            check_poly($sformatf("rnd%0d", p));
            release_poly();
        end

        // Reset mid-fill after 100 accepts, then in FULL.
        rand_coeffs();
        feed(100, 1'b0, 100);
        repeat (3) tick();
        reset_pulse("rst_fill");
        rand_coeffs();
        feed(70, 1'b0, 256);
        drain();
        check_poly("after_rst_fill");
        reset_pulse("rst_full");
        rand_coeffs();
        feed(60, 1'b0, 256);
        drain();
        check_poly("after_rst_full");
        release_poly();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
